fu_sequencer: RTL and testbench

// Initiator side of the FunctionalUnit opcode/operand/result/status interface.

---
 rtl/fu_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_fu_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_sequencer.sv
// rtl/fu_sequencer.sv - FunctionalUnit initiator: single FU ops and 16-cycle shift-add multiply
//
// Purpose: accepts macro-op requests over valid/ready, drives the external
// combinational FU through registered fu_a/fu_b/fu_opcode, and returns a
// registered response held until rsp_ready_i.
//
// Ports:
//   clk_i, rst_n_i                       clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o              request handshake; ready only in IDLE
//   req_op_i, req_x_i, req_y_i           0,op[3:0] = single FU op; 10000 = MULU; 10001 = MULS
//   fu_a_o, fu_b_o, fu_opcode_o          FU operands and opcode
//   fu_result_i, fu_status_i             FU result and flags {V,C,Z,N}
//   rsp_valid_o/rsp_ready_i              response handshake
//   rsp_data_o, rsp_aux_o                result (or product low) and product high
//   rsp_status_o, rsp_err_o              {V,C,Z,N} and illegal-op flag
//
// Configuration: FU_SEQ_SIGNED_MUL_EN enables MULS (magnitude multiply plus a
// FIX cycle that negates the product when the operand signs differ).
module fu_sequencer #(
    parameter int              DATA_W      = 16,
    parameter int              OP_W        = 5,
    parameter logic [3:0]      IDLE_OPCODE = 4'b0000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [OP_W-1:0]   req_op_i,
    input  logic [DATA_W-1:0] req_x_i,
    input  logic [DATA_W-1:0] req_y_i,
    output logic [DATA_W-1:0] fu_a_o,
    output logic [DATA_W-1:0] fu_b_o,
    output logic [3:0]        fu_opcode_o,
    input  logic [DATA_W-1:0] fu_result_i,
    input  logic [3:0]        fu_status_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [DATA_W-1:0] rsp_aux_o,
    output logic [3:0]        rsp_status_o,
    output logic              rsp_err_o
);

    localparam logic [OP_W-1:0]   OP_MULU = 5'b10000;
    localparam logic [3:0]        FU_ADD  = 4'b0100;
    localparam logic [DATA_W-1:0] ZERO    = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
`ifdef FU_SEQ_SIGNED_MUL_EN
        S_FIX,
`endif
        S_RESP
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   x_q, acc_q, mplr_q;
    logic [3:0]          cnt_q;
    logic [DATA_W-1:0]   fu_a_q, fu_b_q;
    logic [3:0]          fu_op_q;
    logic                rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_data_q, rsp_aux_q;
    logic [3:0]          rsp_status_q;

    // One shift-add step: {C, sum, mplr} >> 1.
    logic [DATA_W-1:0]   acc_d, mplr_d;
    logic [2*DATA_W-1:0] prod_d;
    assign acc_d  = {fu_status_i[2], fu_result_i[DATA_W-1:1]};
    assign mplr_d = {fu_result_i[0], mplr_q[DATA_W-1:1]};
    assign prod_d = {acc_d, mplr_d};

    logic is_single, is_mulu, is_muls;
    logic [DATA_W-1:0] mx_d, my_d;
    assign is_single = ~req_op_i[OP_W-1];
    assign is_mulu   = (req_op_i == OP_MULU);

`ifdef FU_SEQ_SIGNED_MUL_EN
    localparam logic [OP_W-1:0]     OP_MULS = 5'b10001;
    localparam logic [2*DATA_W-1:0] ONE2    = 1;
    logic                sign_q, muls_q;
    logic [2*DATA_W-1:0] fix_d;
    assign is_muls = (req_op_i == OP_MULS);
    // 0x8000 has no positive 16-bit twin; its negation wraps back to 0x8000,
    // which is the correct unsigned magnitude.
    assign mx_d = (is_muls && req_x_i[DATA_W-1]) ? ZERO - req_x_i : req_x_i;
    assign my_d = (is_muls && req_y_i[DATA_W-1]) ? ZERO - req_y_i : req_y_i;
    assign fix_d = sign_q ? (~{acc_q, mplr_q}) + ONE2 : {acc_q, mplr_q};
`else
    assign is_muls = 1'b0;
    assign mx_d    = req_x_i;
    assign my_d    = req_y_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            acc_q        <= '0;
            mplr_q       <= '0;
            cnt_q        <= '0;
            fu_a_q       <= '0;
            fu_b_q       <= '0;
            fu_op_q      <= IDLE_OPCODE;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_aux_q    <= '0;
            rsp_status_q <= '0;
`ifdef FU_SEQ_SIGNED_MUL_EN
            sign_q       <= 1'b0;
            muls_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (is_single) begin
                            fu_a_q  <= req_x_i;
                            fu_b_q  <= req_y_i;
                            fu_op_q <= req_op_i[3:0];
                            state_q <= S_EXEC;
                        end else if (is_mulu || is_muls) begin
                            x_q     <= mx_d;
                            mplr_q  <= my_d;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            fu_a_q  <= '0;
                            fu_b_q  <= my_d[0] ? mx_d : ZERO;
                            fu_op_q <= FU_ADD;
`ifdef FU_SEQ_SIGNED_MUL_EN
                            muls_q  <= is_muls;
                            sign_q  <= is_muls & (req_x_i[DATA_W-1] ^ req_y_i[DATA_W-1]);
`endif
                            state_q <= S_MUL;
                        end else begin
                            rsp_valid_q  <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            rsp_data_q   <= '0;
                            rsp_aux_q    <= '0;
                            rsp_status_q <= '0;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_err_q    <= 1'b0;
                    rsp_data_q   <= fu_result_i;
                    rsp_aux_q    <= '0;
                    rsp_status_q <= fu_status_i;
                    fu_a_q       <= '0;
                    fu_b_q       <= '0;
                    fu_op_q      <= IDLE_OPCODE;
                    state_q      <= S_RESP;
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_d;
                    cnt_q  <= cnt_q + 4'd1;
                    fu_a_q <= acc_d;
                    fu_b_q <= mplr_d[0] ? x_q : ZERO;
                    if (cnt_q == 4'd15) begin
                        fu_a_q  <= '0;
                        fu_b_q  <= '0;
                        fu_op_q <= IDLE_OPCODE;
`ifdef FU_SEQ_SIGNED_MUL_EN
                        if (muls_q) begin
                            state_q <= S_FIX;
                        end else
`endif
                        begin
                            rsp_valid_q  <= 1'b1;
                            rsp_err_q    <= 1'b0;
                            rsp_aux_q    <= prod_d[2*DATA_W-1:DATA_W];
                            rsp_data_q   <= prod_d[DATA_W-1:0];
                            rsp_status_q <= {2'b00, prod_d == '0, prod_d[2*DATA_W-1]};
                            state_q      <= S_RESP;
                        end
                    end
                end
`ifdef FU_SEQ_SIGNED_MUL_EN
                S_FIX: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_err_q    <= 1'b0;
                    rsp_aux_q    <= fix_d[2*DATA_W-1:DATA_W];
                    rsp_data_q   <= fix_d[DATA_W-1:0];
                    rsp_status_q <= {2'b00, fix_d == '0, fix_d[2*DATA_W-1]};
                    state_q      <= S_RESP;
                end
`endif
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign fu_a_o       = fu_a_q;
    assign fu_b_o       = fu_b_q;
    assign fu_opcode_o  = fu_op_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_aux_o    = rsp_aux_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_fu_sequencer.sv
// tb/tb_fu_sequencer.sv - scoreboard bench for fu_sequencer with a behavioural FU and reference model
module tb_fu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [15:0] req_x, req_y;
    logic [15:0] fu_a, fu_b, fu_result;
    logic [3:0]  fu_opcode, fu_status;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data, rsp_aux;
    logic [3:0]  rsp_status;
    logic        rsp_err;

    always #5 clk = ~clk;

    fu_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_x_i(req_x), .req_y_i(req_y),
        .fu_a_o(fu_a), .fu_b_o(fu_b), .fu_opcode_o(fu_opcode),
        .fu_result_i(fu_result), .fu_status_i(fu_status),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_aux_o(rsp_aux),
        .rsp_status_o(rsp_status), .rsp_err_o(rsp_err)
    );

    // Behavioural FU: returns {V,C,Z,N, result}.
    function automatic logic [19:0] fu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; w = '0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~a;
            4'd4: begin
                w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd5: begin
                w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd6: r = a << 1;
            4'd7: r = a >> 1;
            default: r = b;
        endcase
        return {v, c, (r == 16'd0), r[15], r};
    endfunction

    assign {fu_status, fu_result} = fu_calc(fu_opcode, fu_a, fu_b);

    typedef struct {
        logic [15:0] data;
        logic [15:0] aux;
        logic [3:0]  st;
        logic        err;
        int          rise;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rr_mode = 2;   // 0 random, 1 hold low, 2 hold high

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model from the arithmetic meaning of each op.
    function automatic exp_t model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y, input int acc_edge);
        exp_t e;
        logic [19:0] f;
        logic [31:0] p;
        int lat;
        e.data = '0; e.aux = '0; e.st = '0; e.err = 1'b0;
        if (!op[4]) begin
            f = fu_calc(op[3:0], x, y);
            e.data = f[15:0]; e.st = f[19:16]; lat = 2;
        end else if (op == 5'b10000) begin
            p = {16'd0, x} * {16'd0, y};
            e.data = p[15:0]; e.aux = p[31:16]; e.st = {2'b00, p == 32'd0, p[31]}; lat = 17;
`ifdef FU_SEQ_SIGNED_MUL_EN
        end else if (op == 5'b10001) begin
            p = $signed({{16{x[15]}}, x}) * $signed({{16{y[15]}}, y});
            e.data = p[15:0]; e.aux = p[31:16]; e.st = {2'b00, p == 32'd0, p[31]}; lat = 18;
`endif
        end else begin
            e.err = 1'b1; lat = 1;
        end
        e.rise = acc_edge + lat - 1;
        return e;
    endfunction

    // Presents one request and returns just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                chk("req_accept_timeout", 32'd0, 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        q.push_back(model(op, x, y, cyc + 1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: rsp_ready = 1'($urandom_range(0, 1));
                1: rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops on each new response, then checks it stays stable.
    logic        prev_v = 1'b0;
    logic [36:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid) begin
                chk("req_ready_during_resp", {31'd0, req_ready}, 32'd0);
                if (!prev_v) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                        chk("rsp_aux", {16'd0, rsp_aux}, {16'd0, e.aux});
                        chk("rsp_status", {28'd0, rsp_status}, {28'd0, e.st});
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        chk("rsp_latency_cycle", cyc, e.rise);
                    end
                    held = {rsp_data, rsp_aux, rsp_status, rsp_err};
                end else begin
                    chk("rsp_stable", {27'd0, 5'(held[4:0])} ^ {rsp_data, rsp_aux} ^ {rsp_data, rsp_aux},
                        {27'd0, rsp_status, rsp_err});
                    chk("rsp_stable_data", {rsp_data, rsp_aux}, held[36:5]);
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_fields"}, {rsp_data, rsp_aux}, 32'd0);
        chk({tag, "_rsp_st_err"}, {27'd0, rsp_status, rsp_err}, 32'd0);
        chk({tag, "_fu_ab"}, {fu_a, fu_b}, 32'd0);
        chk({tag, "_fu_opcode"}, {28'd0, fu_opcode}, 32'd0);
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        logic [4:0] op;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single ops, including a zero-result subtract.
        issue(5'b00000, 16'h0F0F, 16'h00FF);
        issue(5'b00101, 16'h0005, 16'h0003);
        issue(5'b00101, 16'h1234, 16'h1234);

        // Full-range unsigned multiply; the FU sees an add for all 16 steps.
        issue(5'b10000, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("mul_fu_opcode", {28'd0, fu_opcode}, 32'd4);
        end
        issue(5'b10000, 16'h1234, 16'h0000);
        issue(5'b10111, 16'h1111, 16'h2222);
        issue(5'b10001, 16'hFFFE, 16'h0003);

        // Held response: a queued request waits for the handshake.
        rr_mode = 1;
        issue(5'b00100, 16'h7FFF, 16'h0001);
        fork
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
                chk("held_rsp_seen", {31'd0, rsp_valid}, 32'd1);
                repeat (5) @(posedge clk);
                rr_mode = 2;
            end
            issue(5'b00010, 16'hA5A5, 16'h5A5A);
        join

        // Reset in the middle of a multiply drops it.
        issue(5'b10000, 16'hABCD, 16'h1357);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'b10000, 16'h0003, 16'h0005);

        // Randomized mix with random response backpressure.
        rr_mode = 0;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = {1'b0, 4'($urandom)};
                4, 5, 6:    op = 5'b10000;
                7, 8:       op = 5'b10001;
                default:    op = {1'b1, 4'($urandom_range(2, 15))};
            endcase
            issue(op, pick_val(), pick_val());
        end

        rr_mode = 2;
        n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 200) begin @(negedge clk); n++; end
        chk("drain_pending", q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
